image_writer: RTL and testbench

Sink end of the pixel pipeline: accepts the filtered pixel stream (pixel plus valid strobe) from the kernel stage and writes it in raster order into an on-chip frame memory. It provides a synchronous readback port for a host or debug path, plus frame-completion, overflow and checksum status. It replaces the simulation-only file dump of filtered pixels with synthesizable capture.

---
 rtl/image_pkg.sv | 18 +
 rtl/frame_ram.sv | 37 +++
 rtl/image_writer.sv | 109 ++++++++++
 tb/tb_image_writer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared types and constants for the image_writer capture path.
package image_pkg;

    localparam int unsigned PixW  = 8;
    localparam int unsigned CsumW = 16;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StDone
    } state_e;

    // Never let a one-pixel frame collapse the address bus to zero width.
    function automatic int unsigned addr_width(input int unsigned npix);
        return (npix > 1) ? int'($clog2(npix)) : 1;
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame memory: one write port, one registered read-first read port.
module frame_ram #(
    parameter int unsigned Depth = 16,
    parameter int unsigned AddrW = 4,
    parameter int unsigned DataW = 8
) (
    input  logic             pixclk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [AddrW-1:0] wr_addr_i,
    input  logic [DataW-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AddrW-1:0] rd_addr_i,
    output logic [DataW-1:0] rd_data_o
);

    logic [DataW-1:0] mem_q [Depth];
    logic [DataW-1:0] rd_data_q;

    always_ff @(posedge pixclk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Non-blocking read of mem_q gives old data on a same-address write.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/image_writer.sv
// Captures one raster-order frame of filtered pixels into on-chip memory with status and readback.
module image_writer
    import image_pkg::*;
#(
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned HIGHT  = 256,
    localparam int unsigned NPIX   = WIDTH * HIGHT,
    localparam int unsigned ADDR_W = addr_width(NPIX)
) (
    input  logic              pixclk,
    input  logic              rst,
    input  logic              arm_i,
    input  logic              pix_valid_i,
    input  logic [PixW-1:0]   pix_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [PixW-1:0]   rd_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              frame_done_o,
    output logic              overflow_o,
    output logic [ADDR_W:0]   pix_count_o,
    output logic [CsumW-1:0]  checksum_o
);

    localparam logic [ADDR_W:0] LastCnt = (ADDR_W + 1)'(NPIX - 1);
    localparam logic [ADDR_W:0] CntOne  = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [CsumW-1:0]  csum_q, csum_d;
    logic              ovf_q, ovf_d;
    logic              fdone_q, fdone_d;
    logic              wr_en;

    always_ff @(posedge pixclk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            csum_q  <= '0;
            ovf_q   <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            ovf_q   <= ovf_d;
            fdone_q <= fdone_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        ovf_d   = ovf_q;
        fdone_d = 1'b0;
        wr_en   = 1'b0;
        // arm takes priority over any pixel arriving on the same cycle.
        if (arm_i) begin
            state_d = StCapture;
            cnt_d   = '0;
            csum_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StCapture: begin
                    if (pix_valid_i) begin
                        wr_en  = 1'b1;
                        cnt_d  = cnt_q + CntOne;
                        csum_d = csum_q + CsumW'(pix_data_i);
                        if (cnt_q == LastCnt) begin
                            state_d = StDone;
                            fdone_d = 1'b1;
                        end
                    end
                end
                default: begin
                    if (pix_valid_i) begin
                        ovf_d = 1'b1;
                    end
                end
            endcase
        end
    end

    frame_ram #(
        .Depth(NPIX),
        .AddrW(ADDR_W),
        .DataW(PixW)
    ) u_frame_ram (
        .pixclk   (pixclk),
        .rst      (rst),
        .wr_en_i  (wr_en),
        .wr_addr_i(cnt_q[ADDR_W-1:0]),
        .wr_data_i(pix_data_i),
        .rd_en_i  (rd_en_i),
        .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o)
    );

    assign busy_o       = (state_q == StCapture);
    assign done_o       = (state_q == StDone);
    assign frame_done_o = fdone_q;
    assign overflow_o   = ovf_q;
    assign pix_count_o  = cnt_q;
    assign checksum_o   = csum_q;

endmodule

// File: tb/tb_image_writer.sv
// Directed table-driven bench for image_writer on a 4x4 frame.
module tb_image_writer;

    logic        pixclk;
    logic        rst;
    logic        arm;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        done;
    logic        frame_done;
    logic        overflow;
    logic [4:0]  pix_count;
    logic [15:0] checksum;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        arm;
        logic        valid;
        logic [7:0]  data;
        logic        rd_en;
        logic [3:0]  rd_addr;
        logic        busy;
        logic        done;
        logic        fd;
        logic        ovf;
        logic [4:0]  cnt;
        logic [15:0] csum;
        logic        chk_rd;
        logic [7:0]  rd;
    } vec_t;

    vec_t vecs[$];

    image_writer #(
        .WIDTH(4),
        .HIGHT(4)
    ) dut (
        .pixclk      (pixclk),
        .rst         (rst),
        .arm_i       (arm),
        .pix_valid_i (pix_valid),
        .pix_data_i  (pix_data),
        .rd_en_i     (rd_en),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .busy_o      (busy),
        .done_o      (done),
        .frame_done_o(frame_done),
        .overflow_o  (overflow),
        .pix_count_o (pix_count),
        .checksum_o  (checksum)
    );

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pixclk);
        #1;
    endtask

    task automatic chk_status(input string tag, input logic b, input logic dn, input logic fd,
                              input logic ov, input logic [4:0] c, input logic [15:0] cs);
        chk({tag, " busy"}, 32'(busy), 32'(b));
        chk({tag, " done"}, 32'(done), 32'(dn));
        chk({tag, " frame_done"}, 32'(frame_done), 32'(fd));
        chk({tag, " overflow"}, 32'(overflow), 32'(ov));
        chk({tag, " pix_count"}, 32'(pix_count), 32'(c));
        chk({tag, " checksum"}, 32'(checksum), 32'(cs));
    endtask

    function automatic void add(input logic a, input logic v, input logic [7:0] d,
                                input logic re, input logic [3:0] ra, input logic b,
                                input logic dn, input logic fd, input logic ov,
                                input logic [4:0] c, input logic [15:0] cs,
                                input logic cr, input logic [7:0] rd);
        vec_t t;
        t.arm = a;    t.valid = v;  t.data = d;   t.rd_en = re; t.rd_addr = ra;
        t.busy = b;   t.done = dn;  t.fd = fd;    t.ovf = ov;   t.cnt = c;
        t.csum = cs;  t.chk_rd = cr; t.rd = rd;
        vecs.push_back(t);
    endfunction

    initial begin
        int sum;

        // Frame 1: 0x00..0x0F back to back, then read everything back.
        add(1, 0, 8'h00, 0, 4'd0, 1, 0, 0, 0, 5'd0, 16'h0, 0, 8'h00);
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            sum += i;
            add(0, 1, 8'(i), 0, 4'd0, i < 15, i == 15, i == 15, 0, 5'(i + 1), 16'(sum), 0, 8'h00);
        end
        add(0, 0, 8'h00, 0, 4'd0, 0, 1, 0, 0, 5'd16, 16'h0078, 0, 8'h00);
        for (int a = 0; a < 16; a++) begin
            add(0, 0, 8'h00, 1, 4'(a), 0, 1, 0, 0, 5'd16, 16'h0078, 1, 8'(a));
        end
        add(0, 0, 8'h00, 0, 4'd0, 0, 1, 0, 0, 5'd16, 16'h0078, 1, 8'h0F);

        // Frame 2: 0xFF with 3-cycle gaps.
        add(1, 0, 8'h00, 0, 4'd0, 1, 0, 0, 0, 5'd0, 16'h0, 0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            add(0, 1, 8'hFF, 0, 4'd0, i < 15, i == 15, i == 15, 0, 5'(i + 1), 16'(255 * (i + 1)),
                0, 8'h00);
            if (i < 15) begin
                for (int g = 0; g < 3; g++) begin
                    add(0, 0, 8'h00, 0, 4'd0, 1, 0, 0, 0, 5'(i + 1), 16'(255 * (i + 1)), 0, 8'h00);
                end
            end
        end
        add(0, 0, 8'h00, 0, 4'd0, 0, 1, 0, 0, 5'd16, 16'h0FF0, 0, 8'h00);

        // Pixel in DONE sets overflow and touches nothing else.
        add(0, 1, 8'hAA, 0, 4'd0, 0, 1, 0, 1, 5'd16, 16'h0FF0, 0, 8'h00);
        add(0, 0, 8'h00, 1, 4'd0, 0, 1, 0, 1, 5'd16, 16'h0FF0, 1, 8'hFF);
        add(0, 0, 8'h00, 1, 4'd15, 0, 1, 0, 1, 5'd16, 16'h0FF0, 1, 8'hFF);
        add(1, 0, 8'h00, 0, 4'd0, 1, 0, 0, 0, 5'd0, 16'h0, 0, 8'h00);

        // 5 pixels, arm+pixel collision, then a full frame 0x10..0x1F.
        sum = 0;
        for (int i = 0; i < 5; i++) begin
            sum += 32 + i;
            add(0, 1, 8'(32 + i), 0, 4'd0, 1, 0, 0, 0, 5'(i + 1), 16'(sum), 0, 8'h00);
        end
        add(1, 1, 8'h55, 0, 4'd0, 1, 0, 0, 0, 5'd0, 16'h0, 0, 8'h00);
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            sum += 16 + i;
            add(0, 1, 8'(16 + i), 0, 4'd0, i < 15, i == 15, i == 15, 0, 5'(i + 1), 16'(sum),
                0, 8'h00);
        end
        add(0, 0, 8'h00, 1, 4'd0, 0, 1, 0, 0, 5'd16, 16'h0178, 1, 8'h10);
        add(0, 0, 8'h00, 1, 4'd5, 0, 1, 0, 0, 5'd16, 16'h0178, 1, 8'h15);
        add(0, 0, 8'h00, 1, 4'd15, 0, 1, 0, 0, 5'd16, 16'h0178, 1, 8'h1F);

        rst = 1'b1; arm = 1'b0; pix_valid = 1'b0; pix_data = 8'h00; rd_en = 1'b0; rd_addr = 4'd0;
        step();
        step();
        chk_status("reset", 0, 0, 0, 0, 5'd0, 16'h0);
        chk("reset rd_data", 32'(rd_data), 32'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            arm = vecs[i].arm; pix_valid = vecs[i].valid; pix_data = vecs[i].data;
            rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
            step();
            chk_status($sformatf("v%0d", i), vecs[i].busy, vecs[i].done, vecs[i].fd,
                       vecs[i].ovf, vecs[i].cnt, vecs[i].csum);
            if (vecs[i].chk_rd) chk($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(vecs[i].rd));
        end
        arm = 1'b0; pix_valid = 1'b0; rd_en = 1'b0;

        // Reset mid-frame: status zeroed, partial data retained.
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 7; i++) begin
            pix_valid = 1'b1; pix_data = 8'(48 + i); step();
        end
        pix_valid = 1'b0;
        chk_status("pre_rst", 1, 0, 0, 0, 5'd7, 16'(48 * 7 + 21));
        rst = 1'b1; step(); rst = 1'b0;
        chk_status("mid_rst", 0, 0, 0, 0, 5'd0, 16'h0);
        chk("mid_rst rd_data", 32'(rd_data), 32'h0);
        for (int i = 0; i < 7; i++) begin
            rd_en = 1'b1; rd_addr = 4'(i); step();
            chk($sformatf("retain%0d rd_data", i), 32'(rd_data), 32'(48 + i));
        end
        rd_en = 1'b0;

        // Pixel in IDLE sets overflow; arm clears it.
        pix_valid = 1'b1; pix_data = 8'h77; step(); pix_valid = 1'b0;
        chk_status("idle_ovf", 0, 0, 0, 1, 5'd0, 16'h0);
        arm = 1'b1; step(); arm = 1'b0;
        chk_status("idle_arm", 1, 0, 0, 0, 5'd0, 16'h0);

        // Read-first on a same-cycle write/read of address 3.
        for (int i = 0; i < 16; i++) begin
            pix_valid = 1'b1; pix_data = 8'(i); step();
        end
        pix_valid = 1'b0;
        chk_status("raw_frame", 0, 1, 1, 0, 5'd16, 16'h0078);
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1; pix_data = 8'(144 + i); step();
        end
        pix_valid = 1'b1; pix_data = 8'h99; rd_en = 1'b1; rd_addr = 4'd3; step();
        pix_valid = 1'b0;
        chk("raw old rd_data", 32'(rd_data), 32'h03);
        chk("raw pix_count", 32'(pix_count), 32'd4);
        step();
        chk("raw new rd_data", 32'(rd_data), 32'h99);
        rd_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
